hall_velocity_estimator: RTL and testbench
==========================================

Name: hall_velocity_estimator

Overview:
Upstream stage of the BLDC velocity PI controller. Samples the three motor Hall sensors and validates each Hall transition. Counts valid commutation edges over a fixed window of clock cycles, then publishes the count as a 16-bit velocity. Also emits a one-cycle update pulse that drives the controller's enable input, plus direction and fault status.

Parameters:
WINDOW_CYCLES, 50000, measurement window length in clk cycles (1 kHz update at 50 MHz); minimum 4.
CNT_W, 16, edge-count and velocity width; velocity saturates at 2^CNT_W-1.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
hall  input  3  raw Hall sensor levels {C,B,A}, asynchronous to clk
velocity  output  CNT_W  valid edges counted in the last completed window
update  output  1  one-cycle pulse; velocity/direction are new this cycle
direction  output  1  1 = forward, 0 = reverse; from the last valid edge
hall_fault  output  1  sticky flag for an illegal code or an illegal transition

Behaviour:
- One clock domain. Reset is asynchronous and active-high. All outputs are 0 while reset is asserted.
- The hall input passes through a 2-flop synchronizer (reset value 3'b000). All decode logic uses the synchronized value hs.
- Legal codes: 1,3,2,6,4,5. Codes 0 and 7 are illegal.
- Forward successor order: 1→3→2→6→4→5→1. Reverse is the opposite order.
- prev_valid is cleared by reset. While prev_valid=0, hs is ignored for 2 cycles (synchronizer fill).
- On the 3rd cycle after reset, prev is loaded from hs and prev_valid is set. No edge is counted. If the loaded code is illegal, hall_fault sets.
- On every cycle with prev_valid=1 and hs != prev:
  - hs is the forward successor: count the edge, direction register ← 1.
  - hs is the reverse successor: count the edge, direction register ← 0.
  - Otherwise (illegal code or skipped step): hall_fault ← 1, no count.
  - In all three cases, prev ← hs.
- The edge counter saturates at 2^CNT_W-1 and never wraps.
- Window counter: 0 on the first clock after reset release. It counts up to WINDOW_CYCLES-1, then wraps to 0.
- Terminal cycle (count == WINDOW_CYCLES-1):
  - velocity ← edge count, including an edge detected in that same cycle.
  - direction output ← direction register.
  - edge counter ← 0.
  - update is registered high for exactly the next cycle.
- Latency: update first asserts WINDOW_CYCLES clocks after reset release. After that it asserts every WINDOW_CYCLES clocks exactly.
- velocity and direction hold their values between update pulses.
- A window with no edges publishes velocity 0. Direction holds its previous value.
- hall_fault is cleared only by reset.
- Reset mid-window: the partial count is discarded and timing restarts from 0.

Optional Feature:
VELOCITY_FILTER_EN:
- Defined: velocity = (count_this_window + count_prev_window) >> 1, computed at CNT_W+1 bits. count_prev_window resets to 0.
- Not defined: velocity = raw window count.
- Timing of update is identical in both builds.

Test Plan:
(All tests use WINDOW_CYCLES=100, CNT_W=16, filter disabled unless stated.)
1. Reset, then hall held at 3'b001 for 350 cycles → update pulses at clocks 100, 200 and 300 after release; velocity=0; direction=0; hall_fault=0.
2. Forward sequence, one step every 10 clocks, for 5 windows → steady-state velocity=10, direction=1, hall_fault=0.
3. Reverse sequence, one step every 20 clocks → steady-state velocity=5, direction=0 from the first full window.
4. Forward steps, then inject hall=3'b000 for 5 clocks, then resume → hall_fault=1 and stays high. The 0 entry and the exit from 0 are not counted. The window velocity is lower by 1 than an unfaulted run.
5. CNT_W=4, 20 forward steps within one window → velocity=15 (saturated).
6. Forward steps every 10 clocks, assert reset at clock 50 for 3 clocks → all outputs 0 during reset; next update 100 clocks after release. With VELOCITY_FILTER_EN and steady 10 edges/window, the first update after reset shows 5, then 10 thereafter.

Source files
------------

// File: rtl/hall_velocity_estimator.sv
// -----------------------------------------------------------------------------
// hall_velocity_estimator
//
// Front end of the BLDC velocity loop. The raw Hall levels are synchronised,
// every change of the synchronised code is classified as a forward step, a
// reverse step or a fault, and the valid steps are counted over a fixed window
// of WINDOW_CYCLES clocks. At the end of each window the count is published as
// the velocity together with the latest direction, and a one-cycle update
// pulse is raised for the downstream PI controller.
//
// Parameters:
//   WINDOW_CYCLES  window length in clk cycles (>= 4)
//   CNT_W          edge counter / velocity width, saturating at 2^CNT_W-1
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   hall[2:0]   in   raw Hall levels {C,B,A}, asynchronous to clk
//   velocity    out  valid edges counted in the last completed window
//   update      out  one-cycle pulse, velocity/direction are new this cycle
//   direction   out  1 = forward, 0 = reverse (last valid edge)
//   hall_fault  out  sticky illegal-code / illegal-transition flag
//
// Build option:
//   VELOCITY_FILTER_EN  when defined, velocity is the mean of this window's
//                       count and the previous window's count.
// -----------------------------------------------------------------------------
module hall_velocity_estimator #(
  parameter int WINDOW_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       hall,
  output logic [CNT_W-1:0] velocity,
  output logic             update,
  output logic             direction,
  output logic             hall_fault
);

  localparam int               WIN_W    = $clog2(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Codes 0 and 7 never occur on a healthy sensor set.
  function automatic logic is_legal(input logic [2:0] code);
    return (code != 3'd0) && (code != 3'd7);
  endfunction

  // Forward successor: 1->3->2->6->4->5->1.
  function automatic logic [2:0] fwd_next(input logic [2:0] code);
    logic [2:0] nxt;
    case (code)
      3'd1:    nxt = 3'd3;
      3'd3:    nxt = 3'd2;
      3'd2:    nxt = 3'd6;
      3'd6:    nxt = 3'd4;
      3'd4:    nxt = 3'd5;
      3'd5:    nxt = 3'd1;
      default: nxt = 3'd0;
    endcase
    return nxt;
  endfunction

  // Reverse successor: 1->5->4->6->2->3->1.
  function automatic logic [2:0] rev_next(input logic [2:0] code);
    logic [2:0] nxt;
    case (code)
      3'd1:    nxt = 3'd5;
      3'd5:    nxt = 3'd4;
      3'd4:    nxt = 3'd6;
      3'd6:    nxt = 3'd2;
      3'd2:    nxt = 3'd3;
      3'd3:    nxt = 3'd1;
      default: nxt = 3'd0;
    endcase
    return nxt;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
  endfunction

  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       hs_q, hs_d;
  logic [1:0]       fill_q, fill_d;
  logic             prev_valid_q, prev_valid_d;
  logic [2:0]       prev_q, prev_d;
  logic             dir_q, dir_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] velocity_q, velocity_d;
  logic             update_q, update_d;
  logic             direction_q, direction_d;
  logic             edge_ok;
  logic             terminal;
  logic [CNT_W-1:0] cnt_inc;
`ifdef VELOCITY_FILTER_EN
  logic [CNT_W-1:0] prev_cnt_q, prev_cnt_d;
  logic [CNT_W:0]   cnt_sum;
`endif

  // Synchroniser, prev-code tracking and edge classification.
  always_comb begin
    sync1_d      = hall;
    hs_d         = sync1_q;
    fill_d       = fill_q;
    prev_valid_d = prev_valid_q;
    prev_d       = prev_q;
    dir_d        = dir_q;
    fault_d      = fault_q;
    edge_ok      = 1'b0;
    if (!prev_valid_q) begin
      // Wait two clocks for the synchroniser to fill, then seed prev.
      if (fill_q == 2'd2) begin
        prev_d       = hs_q;
        prev_valid_d = 1'b1;
        fault_d      = fault_q | ~is_legal(hs_q);
      end else begin
        fill_d = fill_q + 2'd1;
      end
    end else if (hs_q != prev_q) begin
      prev_d = hs_q;
      // An illegal prev has no successor, so any change away from it is a fault.
      if (is_legal(prev_q) && (hs_q == fwd_next(prev_q))) begin
        edge_ok = 1'b1;
        dir_d   = 1'b1;
      end else if (is_legal(prev_q) && (hs_q == rev_next(prev_q))) begin
        edge_ok = 1'b1;
        dir_d   = 1'b0;
      end else begin
        fault_d = 1'b1;
      end
    end else begin
      prev_d = prev_q;
    end
  end

  // Window timing, edge accumulation and publication at the terminal cycle.
  always_comb begin
    terminal    = (win_q == WIN_LAST);
    cnt_inc     = edge_ok ? sat_inc(edge_cnt_q) : edge_cnt_q;
    win_d       = terminal ? {WIN_W{1'b0}} : win_q + WIN_W'(1);
    edge_cnt_d  = cnt_inc;
    velocity_d  = velocity_q;
    direction_d = direction_q;
    update_d    = 1'b0;
`ifdef VELOCITY_FILTER_EN
    prev_cnt_d  = prev_cnt_q;
    cnt_sum     = {1'b0, cnt_inc} + {1'b0, prev_cnt_q};
`endif
    if (terminal) begin
      // The edge seen in the terminal cycle belongs to the closing window.
      edge_cnt_d  = {CNT_W{1'b0}};
`ifdef VELOCITY_FILTER_EN
      velocity_d  = cnt_sum[CNT_W:1];
      prev_cnt_d  = cnt_inc;
`else
      velocity_d  = cnt_inc;
`endif
      direction_d = dir_d;
      update_d    = 1'b1;
    end else begin
      update_d    = 1'b0;
    end
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= 3'd0;
      hs_q         <= 3'd0;
      fill_q       <= 2'd0;
      prev_valid_q <= 1'b0;
      prev_q       <= 3'd0;
      dir_q        <= 1'b0;
      fault_q      <= 1'b0;
      edge_cnt_q   <= {CNT_W{1'b0}};
      win_q        <= {WIN_W{1'b0}};
      velocity_q   <= {CNT_W{1'b0}};
      update_q     <= 1'b0;
      direction_q  <= 1'b0;
`ifdef VELOCITY_FILTER_EN
      prev_cnt_q   <= {CNT_W{1'b0}};
`endif
    end else begin
      sync1_q      <= sync1_d;
      hs_q         <= hs_d;
      fill_q       <= fill_d;
      prev_valid_q <= prev_valid_d;
      prev_q       <= prev_d;
      dir_q        <= dir_d;
      fault_q      <= fault_d;
      edge_cnt_q   <= edge_cnt_d;
      win_q        <= win_d;
      velocity_q   <= velocity_d;
      update_q     <= update_d;
      direction_q  <= direction_d;
`ifdef VELOCITY_FILTER_EN
      prev_cnt_q   <= prev_cnt_d;
`endif
    end
  end

  assign velocity   = velocity_q;
  assign update     = update_q;
  assign direction  = direction_q;
  assign hall_fault = fault_q;

endmodule

// File: tb/tb_hall_velocity_estimator.sv
// Directed bench for hall_velocity_estimator (WINDOW_CYCLES=100). Expected
// window results are queued as stimulus is issued; monitors pop and compare
// on every update pulse. A second instance with CNT_W=4 covers saturation.
module tb_hall_velocity_estimator;

  localparam int W = 100;
`ifdef VELOCITY_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  typedef struct {
    int vel;
    bit dir;
    bit fault;
    int cyc;
  } exp_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        rst4  = 1'b0;
  logic [2:0]  hall  = 3'd1;
  logic [2:0]  hall4 = 3'd1;
  logic [15:0] velocity;
  logic        update, direction, hall_fault;
  logic [3:0]  velocity4;
  logic        update4, direction4, hall_fault4;

  exp_t exp_q[$];
  exp_t exp4_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   cyc4     = 0;

  logic [2:0] fwd [6] = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd4, 3'd5};
  logic [2:0] rev [6] = '{3'd1, 3'd5, 3'd4, 3'd6, 3'd2, 3'd3};

  hall_velocity_estimator #(.WINDOW_CYCLES(W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .hall(hall), .velocity(velocity),
    .update(update), .direction(direction), .hall_fault(hall_fault)
  );

  hall_velocity_estimator #(.WINDOW_CYCLES(W), .CNT_W(4)) dut4 (
    .clk(clk), .reset(rst4), .hall(hall4), .velocity(velocity4),
    .update(update4), .direction(direction4), .hall_fault(hall_fault4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
    if (rst4)  cyc4 <= 0;
    else       cyc4 <= cyc4 + 1;
  end

  function automatic int filt(input int cur, input int prv);
    return FILT ? (cur + prv) / 2 : cur;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input int vel, input bit dir, input bit fault, input int c);
    exp_t e;
    e.vel = vel; e.dir = dir; e.fault = fault; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic push4(input int vel, input bit dir, input bit fault, input int c);
    exp_t e;
    e.vel = vel; e.dir = dir; e.fault = fault; e.cyc = c;
    exp4_q.push_back(e);
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_velocity", velocity, 0);
    check("rst_update", update, 0);
    check("rst_direction", direction, 0);
    check("rst_fault", hall_fault, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic do_reset4();
    rst4 = 1'b1;
    #1;
    check("rst4_velocity", velocity4, 0);
    check("rst4_update", update4, 0);
    repeat (3) @(posedge clk);
    #1;
    rst4 = 1'b0;
  endtask

  // Scoreboard monitor for the CNT_W=16 instance.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && update === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_update: update at cycle %0d, none expected", cyc);
      end else begin
        e = exp_q.pop_front();
        check("update_cycle", cyc, e.cyc);
        check("velocity", velocity, e.vel);
        check("direction", direction, e.dir);
        check("hall_fault", hall_fault, e.fault);
      end
    end
  end

  // Scoreboard monitor for the CNT_W=4 instance.
  always @(negedge clk) begin : mon4
    exp_t e;
    if (!rst4 && update4 === 1'b1) begin
      if (exp4_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_update4: update at cycle %0d, none expected", cyc4);
      end else begin
        e = exp4_q.pop_front();
        check("update4_cycle", cyc4, e.cyc);
        check("velocity4", velocity4, e.vel);
        check("direction4", direction4, e.dir);
        check("hall_fault4", hall_fault4, e.fault);
      end
    end
  end

  initial begin
    #2;
    rst4 = 1'b1;

    // 1: constant hall, three empty windows.
    hall = 3'd1;
    do_reset();
    for (int k = 1; k <= 3; k++) push(0, 1'b0, 1'b0, k * W);
    run(350);
    check("t1_queue_empty", exp_q.size(), 0);

    // 2: forward step every 10 clocks -> 10 edges per window.
    hall = 3'd1;
    do_reset();
    for (int k = 1; k <= 5; k++) push(filt(10, (k == 1) ? 0 : 10), 1'b1, 1'b0, k * W);
    run(5);
    for (int i = 0; i < 50; i++) begin
      hall = fwd[(i + 1) % 6];
      run(10);
    end
    check("t2_queue_empty", exp_q.size(), 0);

    // 3: reverse step every 20 clocks -> 5 edges per window.
    hall = 3'd1;
    do_reset();
    for (int k = 1; k <= 5; k++) push(filt(5, (k == 1) ? 0 : 5), 1'b0, 1'b0, k * W);
    run(5);
    for (int i = 0; i < 25; i++) begin
      hall = rev[(i + 1) % 6];
      run(20);
    end
    check("t3_queue_empty", exp_q.size(), 0);

    // 4: illegal code 0 injected in place of one forward step.
    hall = 3'd1;
    do_reset();
    push(filt(10, 0), 1'b1, 1'b0, 1 * W);
    push(filt(9, 10), 1'b1, 1'b1, 2 * W);
    push(filt(10, 9), 1'b1, 1'b1, 3 * W);
    run(5);
    for (int i = 0; i < 30; i++) begin
      if (i == 15) begin
        hall = 3'd0;
        run(5);
        check("t4_fault_set", hall_fault, 1);
        hall = fwd[(i + 1) % 6];
        run(5);
      end else begin
        hall = fwd[(i + 1) % 6];
        run(10);
      end
    end
    check("t4_fault_sticky", hall_fault, 1);
    check("t4_queue_empty", exp_q.size(), 0);

    // 5: CNT_W=4, 20 forward steps in one window -> saturates at 15.
    reset = 1'b1;
    hall4 = 3'd1;
    do_reset4();
    push4(filt(15, 0), 1'b1, 1'b0, 1 * W);
    push4(filt(0, 15), 1'b1, 1'b0, 2 * W);
    run(5);
    for (int i = 0; i < 20; i++) begin
      hall4 = fwd[(i + 1) % 6];
      run(4);
    end
    run(120);
    check("t5_queue_empty", exp4_q.size(), 0);
    rst4 = 1'b1;

    // 6: reset mid-window discards the partial count and restarts timing.
    hall = 3'd1;
    do_reset();
    push(filt(10, 0), 1'b1, 1'b0, 1 * W);
    run(5);
    for (int i = 0; i < 14; i++) begin
      hall = fwd[(i + 1) % 6];
      run(10);
    end
    hall = fwd[15 % 6];
    run(5);
    check("t6_pre_reset_dir", direction, 1);
    do_reset();
    push(filt(10, 0), 1'b1, 1'b0, 1 * W);
    push(filt(10, 10), 1'b1, 1'b0, 2 * W);
    run(5);
    for (int i = 15; i < 35; i++) begin
      hall = fwd[(i + 1) % 6];
      run(10);
    end
    check("t6_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
